// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_arbiter_pkg : shared types for the data RAM arbiter         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_NORMAL = 2'd0,
    ARB_FORCE  = 2'd1,
    ARB_HALT   = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_arbiter : shares the data RAM between CPU and ext master    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = 18,
  parameter int unsigned WORD_SIZE    = 18,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic                 cpu_write_enable,
  input  logic [WORD_SIZE-1:0] cpu_in,
  output logic                 cpu_stall,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [ADDR_SIZE-1:0] ext_addr,
  input  logic [WORD_SIZE-1:0] ext_wdata,
  input  logic                 ext_lock,
  output logic                 ext_ack,
  output logic                 ext_rvalid,
  output logic [WORD_SIZE-1:0] ext_rdata,
  output logic [ADDR_SIZE-1:0] memory_addr,
  output logic                 memory_write_enable,
  output logic [WORD_SIZE-1:0] memory_in,
  input  logic [WORD_SIZE-1:0] memory_out
);

  localparam int unsigned      CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             rvalid_q, rvalid_d;

  logic             cpu_gnt;
  logic             ext_gnt;
  logic             ext_denied;
  logic             starve_hit;

  // Grants are masked during reset so nothing reaches the RAM or the master.
  always_comb begin
    cpu_gnt   = 1'b0;
    ext_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (!reset) begin
      case (state_q)
        ARB_NORMAL: begin
          cpu_gnt = cpu_req;
          ext_gnt = !cpu_req && ext_req;
        end
        ARB_FORCE: begin
          ext_gnt   = ext_req;
          cpu_stall = cpu_req;
        end
        ARB_HALT: begin
          ext_gnt   = ext_req;
          cpu_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ext_denied   = ext_req && !ext_gnt && (state_q == ARB_NORMAL);
    starve_hit   = ext_denied && (starve_cnt_q == CNT_LAST);
    starve_cnt_d = starve_cnt_q;
    if (ext_gnt || !ext_req || starve_hit) begin
      starve_cnt_d = '0;
    end else if (ext_denied) begin
      starve_cnt_d = starve_cnt_q + CNT_ONE;
    end

    // Lock outranks starvation; FORCE and HALT both fall back to NORMAL.
    state_d = ARB_NORMAL;
    if (ext_lock) begin
      state_d = ARB_HALT;
    end else if (starve_hit) begin
      state_d = ARB_FORCE;
    end
  end

  always_comb begin
    memory_addr         = cpu_addr;
    memory_in           = cpu_in;
    memory_write_enable = 1'b0;
    if (ext_gnt) begin
      memory_addr         = ext_addr;
      memory_in           = ext_wdata;
      memory_write_enable = ext_we;
    end else if (cpu_gnt) begin
      memory_write_enable = cpu_write_enable;
    end
  end

  assign rvalid_d   = ext_gnt && !ext_we;
  assign ext_ack    = ext_gnt;
  assign ext_rvalid = rvalid_q && !reset;
  assign ext_rdata  = memory_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_NORMAL;
      starve_cnt_q <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rvalid_q     <= rvalid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_arbiter : self-checking bench for data_mem_arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_write_enable, cpu_stall;
  logic [17:0] cpu_addr, cpu_in;
  logic        ext_req, ext_we, ext_lock, ext_ack, ext_rvalid;
  logic [17:0] ext_addr, ext_wdata, ext_rdata;
  logic [17:0] memory_addr, memory_in, memory_out;
  logic        memory_write_enable;

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];

  always #5 clock = ~clock;

  data_mem_arbiter #(.ADDR_SIZE(18), .WORD_SIZE(18), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_write_enable(cpu_write_enable),
    .cpu_in(cpu_in), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_ack(ext_ack), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .memory_addr(memory_addr), .memory_write_enable(memory_write_enable),
    .memory_in(memory_in), .memory_out(memory_out)
  );

  // Synchronous single-port RAM model, read-first.
  logic [17:0] ram [0:255];
  always @(posedge clock) begin
    if (memory_write_enable) ram[memory_addr[7:0]] <= memory_in;
    memory_out <= ram[memory_addr[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-data scoreboard.
  always @(negedge clock) begin
    if (ext_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got 1 expected 0 at %0t", $time);
      end else begin
        check("ext_rdata", {14'd0, ext_rdata}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic ext_access(input logic we, input logic [17:0] a, input logic [17:0] d);
    int n;
    n = 0;
    ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
    if (!we) exp_q.push_back(d);
    @(negedge clock);
    while (!ext_ack && n < 20) begin
      next_cycle();
      @(negedge clock);
      n++;
    end
    check("ext_ack_wait", {31'd0, ext_ack}, 32'd1);
    next_cycle();
    ext_req = 1'b0;
  endtask

  typedef struct {
    logic cr, cw, er, lk;
    logic st, ak, mw, ea;
  } vec_t;
  vec_t vecs[16];

  function automatic vec_t mk(input logic [7:0] b);
    vec_t v;
    {v.cr, v.cw, v.er, v.lk, v.st, v.ak, v.mw, v.ea} = b;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // cr cw er lk | stall ack mwe ext-addr-on-bus
    vecs[0]  = mk(8'b1100_0010);
    vecs[1]  = mk(8'b1010_0000);
    vecs[2]  = mk(8'b1010_0000);
    vecs[3]  = mk(8'b1010_0000);
    vecs[4]  = mk(8'b1010_0000);
    vecs[5]  = mk(8'b1010_1111);
    vecs[6]  = mk(8'b1000_0000);
    vecs[7]  = mk(8'b0010_0111);
    vecs[8]  = mk(8'b0000_0000);
    vecs[9]  = mk(8'b1010_0000);
    vecs[10] = mk(8'b1010_0000);
    vecs[11] = mk(8'b1010_0000);
    vecs[12] = mk(8'b1011_0000);
    vecs[13] = mk(8'b0001_1000);
    vecs[14] = mk(8'b1010_1111);
    vecs[15] = mk(8'b1100_0010);

    // Reset with every request active.
    reset = 1'b1;
    cpu_req = 1'b1; cpu_write_enable = 1'b1; cpu_addr = 18'h5; cpu_in = 18'h7;
    ext_req = 1'b1; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = 18'h6; ext_wdata = 18'h0;
    repeat (3) next_cycle();
    @(negedge clock);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_ack", {31'd0, ext_ack}, 32'd0);
    check("rst_mwe", {31'd0, memory_write_enable}, 32'd0);
    check("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
    next_cycle();
    reset = 1'b0; cpu_req = 1'b0; ext_req = 1'b0; cpu_write_enable = 1'b0;
    @(negedge clock);
    check("post_rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("post_rst_cnt", 32'(dut.starve_cnt_q), 32'd0);
    next_cycle();

    // Arbitration vectors: starvation, force slot, idle slot, lock vs starvation.
    cpu_addr = 18'h11; cpu_in = 18'h111; ext_addr = 18'h31; ext_wdata = 18'h333; ext_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cpu_req = vecs[i].cr; cpu_write_enable = vecs[i].cw;
      ext_req = vecs[i].er; ext_lock = vecs[i].lk;
      @(negedge clock);
      check($sformatf("vec%0d_stall", i), {31'd0, cpu_stall}, {31'd0, vecs[i].st});
      check($sformatf("vec%0d_ack", i), {31'd0, ext_ack}, {31'd0, vecs[i].ak});
      check($sformatf("vec%0d_mwe", i), {31'd0, memory_write_enable}, {31'd0, vecs[i].mw});
      check($sformatf("vec%0d_addr", i), {14'd0, memory_addr},
            vecs[i].ea ? 32'h31 : 32'h11);
      next_cycle();
    end
    cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0; cpu_write_enable = 1'b0;
    next_cycle();

    // CPU-only write of an all-ones word.
    cpu_req = 1'b1; cpu_write_enable = 1'b1; cpu_addr = 18'h10; cpu_in = 18'h3FFFF;
    @(negedge clock);
    check("cpu_mwe", {31'd0, memory_write_enable}, 32'd1);
    check("cpu_addr", {14'd0, memory_addr}, 32'h10);
    check("cpu_wdata", {14'd0, memory_in}, 32'h3FFFF);
    check("cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("cpu_ack", {31'd0, ext_ack}, 32'd0);
    next_cycle();
    cpu_addr = 18'h20; cpu_in = 18'h155;
    next_cycle();
    cpu_req = 1'b0; cpu_write_enable = 1'b0;

    // Ext idle-slot reads with explicit rvalid timing.
    ext_access(1'b0, 18'h20, 18'h155);
    @(negedge clock);
    check("rd_rvalid_n1", {31'd0, ext_rvalid}, 32'd1);
    next_cycle();
    @(negedge clock);
    check("rd_rvalid_n2", {31'd0, ext_rvalid}, 32'd0);
    next_cycle();
    ext_access(1'b0, 18'h10, 18'h3FFFF);
    next_cycle();

    // Lock: three back-to-back ext writes while the CPU keeps requesting.
    for (int c = 0; c < 8; c++) begin
      ext_lock = (c < 6); cpu_req = 1'b1; cpu_write_enable = 1'b0;
      ext_we = 1'b1; ext_req = (c < 4);
      ext_addr = (c < 2) ? 18'h40 : 18'h40 + 18'(c - 1);
      ext_wdata = ext_addr ^ 18'h2AAAA;
      @(negedge clock);
      check($sformatf("lock_c%0d_stall", c), {31'd0, cpu_stall}, {31'd0, (c >= 1 && c <= 6)});
      check($sformatf("lock_c%0d_ack", c), {31'd0, ext_ack}, {31'd0, (c >= 1 && c <= 3)});
      next_cycle();
    end
    cpu_req = 1'b0; ext_lock = 1'b0; ext_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ext_access(1'b0, 18'h40 + 18'(k), (18'h40 + 18'(k)) ^ 18'h2AAAA);
      next_cycle();
    end

    // Reset in the cycle after a read ack.
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 18'h20;
    @(negedge clock);
    check("rstrd_ack", {31'd0, ext_ack}, 32'd1);
    next_cycle();
    ext_req = 1'b0; reset = 1'b1;
    @(negedge clock);
    check("rstrd_rvalid_n1", {31'd0, ext_rvalid}, 32'd0);
    next_cycle();
    @(negedge clock);
    check("rstrd_rvalid_n2", {31'd0, ext_rvalid}, 32'd0);
    check("rstrd_state", 32'(dut.state_q), 32'(ARB_NORMAL));
    check("rstrd_cnt", 32'(dut.starve_cnt_q), 32'd0);
    next_cycle();
    reset = 1'b0;
    repeat (2) next_cycle();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port synchronous data RAM between processor stage 2 (load/store/call push) and one external bus master (debug/UART loader or DMA).
- The processor has priority.
- The external master is guaranteed service by a starvation limit, and can also take exclusive ownership through a lock.
- The block sits between processor_stage2's memory interface and the RAM.
- Its cpu_stall output is ORed into the processor's global wait so that all stages freeze while the processor is denied.

Parameters:
ADDR_SIZE, 18, address width
WORD_SIZE, 18, data word width
STARVE_LIMIT, 4, consecutive cycles ext_req may be denied before a forced external slot (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
cpu_req  in  1  processor needs the port this cycle (stage2 not no_operation and not waiting)
cpu_addr  in  ADDR_SIZE  processor address
cpu_write_enable  in  1  processor write
cpu_in  in  WORD_SIZE  processor write data
cpu_stall  out  1  processor denied this cycle; freeze pipeline
ext_req  in  1  external request; held with stable addr/we/data until ext_ack
ext_we  in  1  external write
ext_addr  in  ADDR_SIZE  external address
ext_wdata  in  WORD_SIZE  external write data
ext_lock  in  1  external master requests exclusive ownership (processor halted)
ext_ack  out  1  external access issued to RAM this cycle
ext_rvalid  out  1  external read data valid (cycle after ack of a read)
ext_rdata  out  WORD_SIZE  external read data
memory_addr  out  ADDR_SIZE  RAM address
memory_write_enable  out  1  RAM write strobe
memory_in  out  WORD_SIZE  RAM write data
memory_out  in  WORD_SIZE  RAM read data, valid one cycle after address

Behaviour:
- Clocking: one clock, synchronous active-high reset.
- Grant decode is combinational from current state and requests. State, the starvation counter and the read-tracking flag are registered.

States (ARB_NORMAL, ARB_FORCE, ARB_HALT). Reset value is ARB_NORMAL.
- ARB_NORMAL:
  - cpu_req=1: cpu granted.
  - cpu_req=0 and ext_req=1: ext granted, ext_ack=1.
  - cpu_stall=0.
- ARB_FORCE:
  - ext granted if ext_req. cpu_stall=cpu_req.
  - Always returns to ARB_NORMAL next cycle.
- ARB_HALT:
  - cpu_stall=1 regardless of cpu_req. ext granted whenever ext_req.
  - Leave to ARB_NORMAL the cycle after ext_lock=0 is sampled.

Transitions and counter:
- ext_lock=1 sampled in any state -> ARB_HALT next cycle. This has priority over starvation.
- starve_cnt increments each ARB_NORMAL cycle with ext_req=1 and no ext grant. It clears on any ext grant or when ext_req=0.
- When starve_cnt==STARVE_LIMIT-1 and ext is denied again -> ARB_FORCE next cycle, and the counter clears.
- Consequence: the maximum ext wait is STARVE_LIMIT cycles.

Datapath:
- Granted side drives memory_addr, memory_in and memory_write_enable (ext: ext_we; cpu: cpu_write_enable).
- With no grant: memory_addr=cpu_addr, memory_write_enable=0.

Read return:
- ext_rvalid is registered: 1 the cycle after an ext_ack with ext_we=0.
- ext_rdata=memory_out. The processor consumes memory_out directly, unchanged.

Reset:
- During and after reset: ext_ack=0, ext_rvalid=0, cpu_stall=0, memory_write_enable=0, starve_cnt=0, state ARB_NORMAL.
- An ext request pending at reset is not acked; the master re-issues it.
- Reset in the cycle after a read ack suppresses ext_rvalid.

Edge cases:
- ext_lock deasserted while ext_req is pending: the pending access is served in ARB_NORMAL under normal priority.
- STARVE_LIMIT=1: ARB_FORCE follows every denied cycle, giving alternating service.

Decomposition:
- Shared processor package: arb_state_t enum (ARB_NORMAL, ARB_FORCE, ARB_HALT).
- Counter width: $clog2(STARVE_LIMIT+1), computed locally.
- No sub-module; the counter and FSM are small enough to keep inline.

Test Plan:
- CPU only: cpu_req=1, write addr 0x10 data 0x3FFFF -> memory_write_enable=1 same cycle, cpu_stall=0, ext_ack never asserted.
- Ext idle-slot read: cpu_req=0, ext read addr 0x20 (RAM holds 0x155) -> ext_ack in cycle N, ext_rvalid=1 with ext_rdata=0x155 in N+1, then ext_rvalid=0.
- Starvation, STARVE_LIMIT=4: cpu_req held 1, ext_req rises cycle 0 -> denied cycles 0-3, cycle 4 ARB_FORCE with ext_ack=1 and cpu_stall=1, cycle 5 cpu granted again.
- Lock: ext_lock=1 from cycle 0, three ext writes back-to-back -> cpu_stall=1 from cycle 1, one ack per cycle. ext_lock low at cycle 6 -> cpu_stall=0 from cycle 7.
- Lock and starvation coincide: counter at STARVE_LIMIT-1 and ext_lock=1 in the same cycle -> next state ARB_HALT, not ARB_FORCE.
- Reset mid-read: ext read acked in cycle N, reset=1 in N+1 -> ext_rvalid=0 in N+1 and N+2, state ARB_NORMAL, starve_cnt=0.
